// File: rtl/stop_watch_if_amisha.sv
// Stopwatch with a 0.1 s prescaler and three BCD digits (d2 d1 . d0, 00.0-99.9).
// The prescaler advances only while go is high and keeps its partial count across
// pauses. A synchronous clear zeroes everything and wins over go and a tick.
module stop_watch_if_amisha #(
  parameter int DVSR = 5000000
) (
  input  logic       clk_amisha,
  input  logic       reset_n_amisha,
  input  logic       go_amisha,
  input  logic       clr_amisha,
  output logic [3:0] d2_amisha,
  output logic [3:0] d1_amisha,
  output logic [3:0] d0_amisha
);

  localparam int            PW   = 23;
  localparam logic [PW-1:0] LAST = PW'(DVSR - 1);
  localparam logic [3:0]    NINE = 4'd9;

  logic [PW-1:0] ps_q, ps_d;
  logic [3:0]    d2_q, d1_q, d0_q;
  logic [3:0]    d2_d, d1_d, d0_d;
  logic          tick;

  // The tick is the last prescaler count of a 0.1 s interval, qualified by go.
  assign tick = go_amisha && (ps_q == LAST);

  // Prescaler next state: clear first, then wrap on tick, then count while go.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ps_d = ps_q;
    if (clr_amisha) begin
      ps_d = '0;
    end else if (tick) begin
      ps_d = '0;
    end else if (go_amisha) begin
      ps_d = ps_q + PW'(1);
    end
  end

  // BCD ripple increment on tick; d2 rolls over so 99.9 becomes 00.0.
  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    if (clr_amisha) begin
      d0_d = '0;
      d1_d = '0;
      d2_d = '0;
    end else if (tick) begin
      if (d0_q == NINE) begin
        d0_d = '0;
        if (d1_q == NINE) begin
          d1_d = '0;
          d2_d = (d2_q == NINE) ? 4'd0 : d2_q + 4'd1;
        end else begin
          d1_d = d1_q + 4'd1;
        end
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  // State register: prescaler and digits, all zeroed asynchronously by reset.
  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n_amisha) begin
      ps_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      ps_q <= ps_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign d2_amisha = d2_q;
  assign d1_amisha = d1_q;
  assign d0_amisha = d0_q;

endmodule

// File: tb/tb_stop_watch_if_amisha.sv
// Directed bench for stop_watch_if_amisha with DVSR=4 (4 go-edges per tick).
// The display is compared as a 12-bit value {d2,d1,d0}, so 05.3 reads as 12'h053.
`timescale 1ns/1ps
module tb_stop_watch_if_amisha;

  localparam int DVSR = 4;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       clr;
  logic [3:0] d2, d1, d0;

  int n_checks = 0;
  int n_pass   = 0;

  stop_watch_if_amisha #(.DVSR(DVSR)) dut (
    .clk_amisha    (clk),
    .reset_n_amisha(rst_n),
    .go_amisha     (go),
    .clr_amisha    (clr),
    .d2_amisha     (d2),
    .d1_amisha     (d1),
    .d0_amisha     (d0)
  );

  // 100 ns clock period, rising edges at 50, 150, 250 ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] disp();
    return {d2, d1, d0};
  endfunction

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One edge with clr high and go low, leaving inputs idle afterwards.
  task automatic clear_dut();
    clr = 1'b1;
    go  = 1'b0;
    step(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    go    = 1'b1;
    clr   = 1'b0;
    #10;
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL reset_async: got %h want 000", disp());
    else n_pass++;
    step(3);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL reset_held: got %h want 000", disp());
    else n_pass++;
    #20 rst_n = 1'b1;
    go = 1'b0;
    step(1);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL reset_release: got %h want 000", disp());
    else n_pass++;
  endtask

  task automatic test_count_latency();
    clear_dut();
    go = 1'b1;
    step(DVSR - 1);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL latency_before: got %h want 000", disp());
    else n_pass++;
    step(1);
    n_checks++;
    if (disp() !== 12'h001) $display("FAIL latency_edge4: got %h want 001", disp());
    else n_pass++;
    step(35);
    n_checks++;
    if (disp() !== 12'h009) $display("FAIL count_39: got %h want 009", disp());
    else n_pass++;
    step(1);
    n_checks++;
    if (disp() !== 12'h010) $display("FAIL count_40: got %h want 010", disp());
    else n_pass++;
    go = 1'b0;
  endtask

  task automatic test_pause();
    int bad = 0;
    clear_dut();
    go = 1'b1;
    step(2);
    go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (disp() !== 12'h000) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL pause_hold: %0d paused edges moved the display, want 0", bad);
    else n_pass++;
    go = 1'b1;
    step(1);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL pause_resume3: got %h want 000", disp());
    else n_pass++;
    step(1);
    n_checks++;
    if (disp() !== 12'h001) $display("FAIL pause_resume4: got %h want 001", disp());
    else n_pass++;
    go = 1'b0;
  endtask

  task automatic test_clear_priority();
    clear_dut();
    go = 1'b1;
    step(53 * DVSR + 3);
    n_checks++;
    if (disp() !== 12'h053) $display("FAIL clr_setup: got %h want 053", disp());
    else n_pass++;
    // Prescaler is at DVSR-1 here, so this edge would otherwise tick.
    clr = 1'b1;
    step(1);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL clr_priority: got %h want 000", disp());
    else n_pass++;
    step(2);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL clr_held: got %h want 000", disp());
    else n_pass++;
    clr = 1'b0;
    step(DVSR - 1);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL clr_restart3: got %h want 000", disp());
    else n_pass++;
    step(1);
    n_checks++;
    if (disp() !== 12'h001) $display("FAIL clr_restart4: got %h want 001", disp());
    else n_pass++;
    go = 1'b0;
  endtask

  task automatic test_carry();
    clear_dut();
    go = 1'b1;
    step(99 * DVSR);
    n_checks++;
    if (disp() !== 12'h099) $display("FAIL carry_099: got %h want 099", disp());
    else n_pass++;
    step(DVSR);
    n_checks++;
    if (disp() !== 12'h100) $display("FAIL carry_100: got %h want 100", disp());
    else n_pass++;
    step(899 * DVSR);
    n_checks++;
    if (disp() !== 12'h999) $display("FAIL carry_999: got %h want 999", disp());
    else n_pass++;
    step(DVSR);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL wrap_000: got %h want 000", disp());
    else n_pass++;
    step(DVSR);
    n_checks++;
    if (disp() !== 12'h001) $display("FAIL wrap_continue: got %h want 001", disp());
    else n_pass++;
    go = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    clear_dut();
    go = 1'b1;
    step(37 * DVSR + 2);
    n_checks++;
    if (disp() !== 12'h037) $display("FAIL rst_mid_setup: got %h want 037", disp());
    else n_pass++;
    #20 rst_n = 1'b0;
    #5;
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL rst_mid_async: got %h want 000", disp());
    else n_pass++;
    step(2);
    #20 rst_n = 1'b1;
    step(DVSR - 1);
    n_checks++;
    if (disp() !== 12'h000) $display("FAIL rst_mid_restart3: got %h want 000", disp());
    else n_pass++;
    step(1);
    n_checks++;
    if (disp() !== 12'h001) $display("FAIL rst_mid_restart4: got %h want 001", disp());
    else n_pass++;
    go = 1'b0;
  endtask

  // go toggles every 100 ns and clr every 150 ns, both 1 ns off a clock edge.
  // A tenths-of-seconds counter model predicts the display at every edge.
  task automatic test_toggle();
    int ps  = 0;
    int cnt = 0;
    int bad_model = 0;
    int bad_range = 0;
    int bad_clr   = 0;
    int clr_edges = 0;
    int ticks     = 0;
    logic       g, c;
    logic [11:0] want;
    clear_dut();
    go  = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk);
      g = go;
      c = clr;
      if (c) begin
        ps  = 0;
        cnt = 0;
      end else if (g) begin
        if (ps == DVSR - 1) begin
          ps  = 0;
          cnt = (cnt + 1) % 1000;
          ticks++;
        end else begin
          ps++;
        end
      end
      #1;
      want = {4'(cnt / 100), 4'((cnt / 10) % 10), 4'(cnt % 10)};
      if (disp() !== want) bad_model++;
      if (d2 > 4'd9 || d1 > 4'd9 || d0 > 4'd9) bad_range++;
      if (c) begin
        clr_edges++;
        if (disp() !== 12'h000) bad_clr++;
      end
      go = ~go;
      if (i % 3 == 0) clr = ~clr;
      if (i % 3 == 1) begin
        #50 clr = ~clr;
      end
    end
    n_checks++;
    if (bad_model != 0) $display("FAIL toggle_model: %0d edges differ from model, want 0", bad_model);
    else n_pass++;
    n_checks++;
    if (bad_range != 0) $display("FAIL toggle_range: %0d edges with a digit above 9, want 0", bad_range);
    else n_pass++;
    n_checks++;
    if (clr_edges == 0 || bad_clr != 0)
      $display("FAIL toggle_clr: %0d of %0d clr edges not 000, want 0 of >0", bad_clr, clr_edges);
    else n_pass++;
    go  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    clr   = 1'b0;
    test_reset();
    test_count_latency();
    test_pause();
    test_clear_priority();
    test_carry();
    test_reset_mid_count();
    test_toggle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
